// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder
//
// Word-addressed memory with two access paths:
//   * an initiator port (mem_operation/addr_i/data_i) served by a small FSM
//     with a configurable number of wait states and a one-cycle opdone pulse;
//   * a host port (host_we/host_addr/host_wdata/host_rdata) that writes on any
//     cycle and reads back with one cycle of latency.
//
// Parameters
//   DEPTH        number of `TYPE_BW-wide words in the store (default 256)
//   WAIT_CYCLES  wait states between request capture and response (0..15)
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   mem_operation[1:0]   00 none, 01 read, 11 write, 10 reserved (sets err)
//   addr_i, data_i       initiator word address / write data (sampled in IDLE)
//   data_o               initiator read data, held until the next read response
//   mem_opdone           one-cycle completion pulse (the RESP cycle)
//   host_we/addr/wdata   host write port
//   host_rdata           host read data, registered, 0 when out of range
//   busy                 high whenever the FSM is not in IDLE
//   err                  sticky: reserved opcode or out-of-range initiator access
//
// Optional feature: define MATRIX_MEM_STATS_EN to add saturating 16-bit
// rd_count / wr_count outputs that count read and write RESP cycles.
//
// The store itself is not reset; only control and output registers are.

`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module matrix_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mem_operation,
  input  logic [31:0]         addr_i,
  input  logic [`TYPE_BW-1:0] data_i,
  output logic [`TYPE_BW-1:0] data_o,
  output logic                mem_opdone,
  input  logic                host_we,
  input  logic [31:0]         host_addr,
  input  logic [`TYPE_BW-1:0] host_wdata,
  output logic [`TYPE_BW-1:0] host_rdata,
  output logic                busy,
  output logic                err
`ifdef MATRIX_MEM_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  localparam int W  = `TYPE_BW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  logic [W-1:0] store [DEPTH];

  state_t       state_q,      state_d;
  logic [3:0]   cnt_q,        cnt_d;
  logic         wr_q,         wr_d;
  logic [31:0]  addr_q,       addr_d;
  logic [W-1:0] wdata_q,      wdata_d;
  logic [W-1:0] data_o_q,     data_o_d;
  logic         opdone_q,     opdone_d;
  logic [W-1:0] host_rdata_q, host_rdata_d;
  logic         busy_q,       busy_d;
  logic         err_q,        err_d;

  logic         req_valid;
  logic         enter_resp;
  logic         next_in_range;
  logic         resp_in_range;
  logic         host_in_range;

  assign req_valid     = (mem_operation == 2'b01) || (mem_operation == 2'b11);
  assign resp_in_range = (addr_q < 32'(DEPTH));
  assign host_in_range = (host_addr < 32'(DEPTH));
  assign next_in_range = (addr_d < 32'(DEPTH));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_o_d     = data_o_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = mem_operation[1];
          addr_d  = addr_i;
          wdata_d = data_i;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end else if (mem_operation == 2'b10) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs for the RESP cycle are prepared on the edge that enters it, so
    // opdone and data_o line up with state RESP. Reading the store here sees
    // its contents before any host write made during RESP, giving old data.
    enter_resp = (state_d == RESP) && (state_q != RESP);
    opdone_d   = enter_resp;
    if (enter_resp) begin
      if (!next_in_range) begin
        err_d = 1'b1;
      end
      if (!wr_d) begin
        data_o_d = next_in_range ? store[addr_d[AW-1:0]] : '0;
      end
    end

    host_rdata_d = host_in_range ? store[host_addr[AW-1:0]] : '0;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_o_q     <= '0;
      opdone_q     <= 1'b0;
      host_rdata_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_o_q     <= data_o_d;
      opdone_q     <= opdone_d;
      host_rdata_q <= host_rdata_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Store: the initiator write commits on the edge that ends RESP. The host
  // write is assigned last so it wins a same-address collision. An async
  // reset forces state IDLE immediately, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q && resp_in_range) begin
      store[addr_q[AW-1:0]] <= wdata_q;
    end
    if (host_we && host_in_range) begin
      store[host_addr[AW-1:0]] <= host_wdata;
    end
  end

  assign data_o     = data_o_q;
  assign mem_opdone = opdone_q;
  assign host_rdata = host_rdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

`ifdef MATRIX_MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == RESP) begin
      if (wr_q) wr_count_d = sat_inc(wr_count_q);
      else      rd_count_d = sat_inc(rd_count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed testbench for matrix_mem_responder (DEPTH=256, WAIT_CYCLES=2).
// Host-port behaviour is driven from a vector table; initiator transactions,
// collisions, error cases and mid-transaction reset are hand-written sequences.

`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module tb_matrix_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          mem_operation;
  logic [31:0]         addr_i;
  logic [`TYPE_BW-1:0] data_i;
  logic [`TYPE_BW-1:0] data_o;
  logic                mem_opdone;
  logic                host_we;
  logic [31:0]         host_addr;
  logic [`TYPE_BW-1:0] host_wdata;
  logic [`TYPE_BW-1:0] host_rdata;
  logic                busy;
  logic                err;
`ifdef MATRIX_MEM_STATS_EN
  logic [15:0]         rd_count;
  logic [15:0]         wr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_operation (mem_operation),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .mem_opdone    (mem_opdone),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .busy          (busy),
    .err           (err)
`ifdef MATRIX_MEM_STATS_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
  } host_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Presents one request for a single cycle and returns the number of clock
  // edges until mem_opdone is seen (capped at 30, which fails any latency check).
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    @(negedge clk);
    mem_operation = op; addr_i = a; data_i = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) mem_operation = 2'b00;
    end while (!mem_opdone && lat < 30);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  host_vec_t hv [9];
  logic [31:0] step_exp [4];
  int lat;
  int n_pulses;
  int last_cyc;
  int pulses;

  initial begin
    hv[0] = '{1'b1, 32'd10,  32'h000000AA, 1'b0, 32'h0};
    hv[1] = '{1'b0, 32'd10,  32'h0,        1'b1, 32'h000000AA};
    hv[2] = '{1'b1, 32'd10,  32'h000000BB, 1'b1, 32'h000000AA};
    hv[3] = '{1'b0, 32'd10,  32'h0,        1'b1, 32'h000000BB};
    hv[4] = '{1'b1, 32'd256, 32'hDEADBEEF, 1'b1, 32'h0};
    hv[5] = '{1'b0, 32'd256, 32'h0,        1'b1, 32'h0};
    hv[6] = '{1'b0, 32'd10,  32'h0,        1'b1, 32'h000000BB};
    hv[7] = '{1'b1, 32'd255, 32'h00000077, 1'b0, 32'h0};
    hv[8] = '{1'b0, 32'd255, 32'h0,        1'b1, 32'h00000077};
    step_exp[0] = 32'd2; step_exp[1] = 32'd3; step_exp[2] = 32'd3; step_exp[3] = 32'd2;

    reset = 1'b1;
    mem_operation = 2'b00; addr_i = '0; data_i = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_opdone", 32'(mem_opdone), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Host port vector table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      host_we = hv[i].we; host_addr = hv[i].addr; host_wdata = hv[i].wdata;
      @(posedge clk); #1;
      if (hv[i].chk) check($sformatf("host_vec%0d", i), host_rdata, hv[i].exp_rdata);
    end
    @(negedge clk);
    host_we = 1'b0;
    check("host_oor_no_err", 32'(err), 32'd0);

    // Host write 5 to addr 0, initiator read: latency WAIT+1, data 5
    host_write(32'd0, 32'd5);
    issue(2'b01, 32'd0, 32'd0, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_data", data_o, 32'd5);
    @(posedge clk); #1;
    check("gap_opdone_low", 32'(mem_opdone), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    wait_idle();

    // Held read request stepping addresses on each opdone
    host_write(32'd0, 32'd2);
    host_write(32'd1, 32'd3);
    host_write(32'd2, 32'd3);
    host_write(32'd3, 32'd2);
    @(negedge clk);
    mem_operation = 2'b01; addr_i = 32'd0;
    n_pulses = 0; last_cyc = -10;
    for (int cyc = 0; cyc < 60 && n_pulses < 4; cyc++) begin
      @(posedge clk); #1;
      if (mem_opdone) begin
        check($sformatf("step_data%0d", n_pulses), data_o, step_exp[n_pulses]);
        if (n_pulses > 0) check($sformatf("step_gap%0d", n_pulses),
                                32'((cyc - last_cyc) >= 2), 32'd1);
        last_cyc = cyc;
        n_pulses++;
        addr_i = 32'(n_pulses);
        if (n_pulses == 4) mem_operation = 2'b00;
      end
    end
    mem_operation = 2'b00;
    check("step_pulses", 32'(n_pulses), 32'd4);
    wait_idle();

    // Same-cycle host write and RESP write to one address: host wins
    issue(2'b11, 32'd30, 32'h00001111, lat);
    check("coll_latency", 32'(lat), 32'd3);
    host_we = 1'b1; host_addr = 32'd30; host_wdata = 32'h00002222;
    @(posedge clk); #1;
    host_we = 1'b0;
    @(posedge clk); #1;
    check("coll_host_wins", host_rdata, 32'h00002222);
    wait_idle();

    // Initiator write then host read back
    issue(2'b11, 32'd20, 32'h00001234, lat);
    check("wr_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    host_addr = 32'd20;
    @(posedge clk); #1;
    check("wr_host_readback", host_rdata, 32'h00001234);
    wait_idle();

    // Out-of-range read, then reserved opcode
    check("pre_oor_err", 32'(err), 32'd0);
    issue(2'b01, 32'(DEPTH), 32'd0, lat);
    check("oor_latency", 32'(lat), 32'd3);
    check("oor_data_o", data_o, 32'd0);
    check("oor_err", 32'(err), 32'd1);
    wait_idle();
    @(negedge clk);
    mem_operation = 2'b10;
    @(posedge clk); #1;
    mem_operation = 2'b00;
    check("rsv_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_opdone) pulses++;
      @(posedge clk); #1;
    end
    check("rsv_no_opdone", 32'(pulses), 32'd0);
    check("rsv_err_sticky", 32'(err), 32'd1);

`ifdef MATRIX_MEM_STATS_EN
    check("stats_rd_count", 32'(rd_count), 32'd6);
    check("stats_wr_count", 32'(wr_count), 32'd2);
`endif

    // Reset mid-WAIT of a write to addr 7
    host_write(32'd7, 32'h00000077);
    @(negedge clk);
    mem_operation = 2'b11; addr_i = 32'd7; data_i = 32'h00000999;
    @(posedge clk); #1;
    mem_operation = 2'b00;
    check("abort_in_wait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_opdone", 32'(mem_opdone), 32'd0);
    check("abort_data_o", data_o, 32'd0);
    check("abort_host_rdata", host_rdata, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
`ifdef MATRIX_MEM_STATS_EN
    check("abort_wr_count", 32'(wr_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mem_opdone) pulses++;
    end
    check("abort_no_opdone", 32'(pulses), 32'd0);
    @(negedge clk);
    host_addr = 32'd7;
    @(posedge clk); #1;
    check("abort_store7", host_rdata, 32'h00000077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
